// File: rtl/shift_reg_univ.sv
// shift_reg_univ: universal shift register with single-step and counted multi-step operation
module shift_reg_univ #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0]       state;
  logic [2:0]       cmode;
  logic [2:0]       emode;
  logic [AMT_W-1:0] cnt;
  logic [WIDTH-1:0] nq;
  logic             is_shift;
  assign emode    = (state == BUSY) ? cmode : mode;
  assign is_shift = (mode >= 3'd2) && (mode <= 3'd6);
  assign busy     = (state == BUSY);
  // One step of the effective mode; load only ever occurs from IDLE
  always_comb
    nq = (emode == 3'd1) ? d :
         (emode == 3'd2) ? {q[WIDTH-2:0], sin} :
         (emode == 3'd3) ? {sin, q[WIDTH-1:1]} :
         (emode == 3'd4) ? {q[WIDTH-2:0], q[WIDTH-1]} :
         (emode == 3'd5) ? {q[0], q[WIDTH-1:1]} :
         (emode == 3'd6) ? {q[WIDTH-1], q[WIDTH-1:1]} :
         (emode == 3'd7) ? '0 : q;
  // Bit that leaves the register on the next step of the effective mode
  always_comb
    sout = (emode == 3'd2 || emode == 3'd4) ? q[WIDTH-1] :
           (emode == 3'd3 || emode == 3'd5 || emode == 3'd6) ? q[0] : 1'b0;
  // Register contents, counted-shift FSM and completion pulse
  always_ff @(posedge clk) begin
    if (clr) begin
      q     <= '0;
      state <= IDLE;
      cnt   <= '0;
      cmode <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && is_shift) begin
          if (amt == '0) begin
            done <= 1'b1;
          end else begin
            cmode <= mode;
            cnt   <= amt;
            state <= BUSY;
          end
        end else if (en) begin
          q <= nq;
        end
      end else if (en) begin
        q   <= nq;
        cnt <= cnt - 1'b1;
        if (cnt == AMT_W'(1)) begin
          state <= IDLE;
          done  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/shift_reg_univ.md
SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

Interface
REQ-001 SHALL have parameter WIDTH, default 8: register width in bits, WIDTH >= 2.
REQ-002 SHALL have parameter AMT_W, default 4: width of the multi-step shift amount.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port clr, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit: step enable; when low, q holds.
REQ-006 SHALL have port mode, input, 3 bits: operation select per REQ-014.
REQ-007 SHALL have port d, input, WIDTH bits: parallel load data.
REQ-008 SHALL have port sin, input, 1 bit: serial input for logical shifts.
REQ-009 SHALL have port start, input, 1 bit: request a multi-step shift.
REQ-010 SHALL have port amt, input, AMT_W bits: number of multi-step shift steps.
REQ-011 SHALL have port q, output, WIDTH bits: registered contents.
REQ-012 SHALL have port sout, output, 1 bit: bit leaving the register on the next step.
REQ-013 SHALL have ports busy (output, 1 bit: multi-step in progress) and done (output, 1 bit: one-cycle completion pulse).

Function
REQ-014 SHALL apply one step per mode as follows:
- 000 hold: q unchanged.
- 001 load: q <= d.
- 010 shl: q <= {q[W-2:0], sin}.
- 011 shr: q <= {sin, q[W-1:1]}.
- 100 rotl: q <= {q[W-2:0], q[W-1]}.
- 101 rotr: q <= {q[0], q[W-1:1]}.
- 110 asr: q <= {q[W-1], q[W-1:1]}.
- 111 clear: q <= 0.
REQ-015 SHALL implement a two-state FSM, IDLE and BUSY; it resets to IDLE.
REQ-016 In IDLE with start=0 and en=1, SHALL apply one step of the mode input on that edge.
REQ-017 In IDLE with start=0 and en=0, SHALL hold q.
REQ-018 In IDLE with start=1, mode in 010..110 and amt>0, SHALL perform these actions on that edge, regardless of en:
- capture mode and amt;
- leave q unchanged;
- enter BUSY.
REQ-019 In IDLE with start=1, a shift/rotate mode (010..110) and amt=0, SHALL leave q unchanged, stay in IDLE and pulse done on the next cycle.
REQ-020 In IDLE with start=1 and mode 000, 001 or 111, SHALL ignore start and behave per REQ-016/REQ-017.
REQ-021 In BUSY, on each edge with en=1, SHALL apply one step of the captured mode and decrement the remaining count.
- Steps SHALL sample the live sin.
- Edges with en=0 SHALL stall both q and the count.
REQ-022 When the step that brings the count to zero is applied, SHALL return to IDLE and assert done for exactly the following cycle.
- Total latency is 1 capture edge plus amt enabled step edges.
REQ-023 busy SHALL be high in every cycle the FSM is in BUSY and low otherwise.
- done and busy SHALL never be high in the same cycle.
REQ-024 In BUSY, SHALL ignore start, mode, amt and d.
REQ-025 sout SHALL be combinational from q and the effective mode, where the effective mode is the captured mode in BUSY and the mode input in IDLE:
- q[W-1] for shl and rotl;
- q[0] for shr, rotr and asr;
- 0 otherwise.
REQ-026 The count register SHALL be AMT_W bits wide; amt = 2^AMT_W-1 SHALL perform exactly that many steps.

Reset
REQ-027 On a clk edge with clr=1, SHALL apply the following, overriding en, start and mode:
- q <= 0;
- FSM <= IDLE;
- count <= 0;
- busy <= 0;
- done <= 0.
REQ-028 clr during BUSY SHALL abort the operation with no done pulse.

Verification (WIDTH=8, AMT_W=4)
REQ-029 Bench SHALL cover clr priority: q=0xA5, clr=1 together with en=1, mode=001, start=1 -> after the edge q=0x00, busy=0, done=0.
REQ-030 Bench SHALL cover single-step operations:
- load d=0x81;
- then rotl with en=1 -> q=0x03;
- then asr -> q=0x01;
- with sout=1 before the rotl.
REQ-031 Bench SHALL cover a multi-step shift: q=0xF0, start with mode=011, amt=3, sin=0, en=1 -> busy high 3 cycles, then q=0x1E and done high for exactly one cycle.
REQ-032 Bench SHALL cover a stall: q=0x01, start shl with amt=2, sin=0, en low for 2 cycles between the steps -> q holds at 0x02 during the stall and ends at 0x04; busy stays high 4 cycles.
REQ-033 Bench SHALL cover an asr multi-step: q=0x80, start asr with amt=4 -> q=0xF8 after completion.
REQ-034 Bench SHALL cover abort and zero amount:
- clr mid-BUSY -> q=0x00, busy=0, no done pulse;
- start with amt=0 -> q unchanged, busy never high, done pulses once.
